cnt_disp: RTL and testbench

Downstream display stage for the 5-bit modulo-18 counter (counts 0..17, then wraps to 0). It samples the counter value and converts it to two decimal digits. It drives a time-multiplexed, 2-digit, common-anode 7-segment display. It also emits a one-cycle pulse each time the counter wraps from its maximum value to zero.

---
 rtl/cnt_disp_if.sv | 11 +
 rtl/cnt_disp.sv | 91 +++++++++
 tb/tb_cnt_disp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_disp_if.sv
// Display-side bundle for the mod-18 counter display stage: the counter value
// flows in, segment/anode drive and the wrap pulse flow out.
interface cnt_disp_if;
  logic [4:0] cnt;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;

  modport master (output cnt, input seg, an, wrap);
  modport slave  (input cnt, output seg, an, wrap);
endinterface

// File: rtl/cnt_disp.sv
// Two-digit multiplexed common-anode 7-segment driver for a modulo-(MAX_VAL+1)
// counter, with a one-cycle pulse on every MAX_VAL->0 wrap.
module cnt_disp #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned MAX_VAL  = 17
) (
  input logic     clk,
  input logic     rstn,
  cnt_disp_if.slave bus
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0]       MAX_CNT  = 5'(MAX_VAL);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [4:0]       cnt_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             digit_sel_q, digit_sel_d;
  logic             wrap_q, wrap_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  logic [3:0] tens, units;
  logic       div_done;

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tens        = 4'(cnt_q / 5'd10);
    units       = 4'(cnt_q % 5'd10);

    // Any divider value at or past the terminal count returns to zero.
    div_done    = (div_q >= DIV_LAST);
    div_d       = div_done ? '0 : div_q + 1'b1;
    digit_sel_d = digit_sel_q ^ div_done;

    wrap_d      = (cnt_q == MAX_CNT) && (bus.cnt == 5'd0);

    an_d        = digit_sel_q ? 2'b01 : 2'b10;
    seg_d       = SEG_BLANK;
    if (cnt_q > MAX_CNT) begin
      seg_d = SEG_DASH;
    end else if (!digit_sel_q) begin
      seg_d = glyph(units);
    end else if (tens != 4'd0) begin
      seg_d = glyph(tens);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      div_q       <= '0;
      digit_sel_q <= 1'b0;
      wrap_q      <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 2'b11;
    end else begin
      cnt_q       <= bus.cnt;
      div_q       <= div_d;
      digit_sel_q <= digit_sel_d;
      wrap_q      <= wrap_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_cnt_disp.sv
// Randomised and directed bench for cnt_disp; three instances with different
// scan dividers are checked against a cycle-count based reference model.
module tb_cnt_disp;

  localparam int MAX_VAL = 17;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] cnt  = 5'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnt_disp_if if_d1 ();
  cnt_disp_if if_d2 ();
  cnt_disp_if if_d4 ();

  assign if_d1.cnt = cnt;
  assign if_d2.cnt = cnt;
  assign if_d4.cnt = cnt;

  cnt_disp #(.SCAN_DIV(1), .MAX_VAL(MAX_VAL)) dut_d1 (.clk(clk), .rstn(rstn), .bus(if_d1.slave));
  cnt_disp #(.SCAN_DIV(2), .MAX_VAL(MAX_VAL)) dut_d2 (.clk(clk), .rstn(rstn), .bus(if_d2.slave));
  cnt_disp #(.SCAN_DIV(4), .MAX_VAL(MAX_VAL)) dut_d4 (.clk(clk), .rstn(rstn), .bus(if_d4.slave));

  logic [6:0] seg_o  [3];
  logic [1:0] an_o   [3];
  logic       wrap_o [3];

  assign seg_o[0] = if_d1.seg;  assign an_o[0] = if_d1.an;  assign wrap_o[0] = if_d1.wrap;
  assign seg_o[1] = if_d2.seg;  assign an_o[1] = if_d2.an;  assign wrap_o[1] = if_d2.wrap;
  assign seg_o[2] = if_d4.seg;  assign an_o[2] = if_d4.an;  assign wrap_o[2] = if_d4.wrap;

  // Reference model: edges since reset release, and the last two sampled cnt values.
  int k;
  int h_prev;
  int h_cur;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k      <= 0;
      h_prev <= 0;
      h_cur  <= 0;
    end else begin
      k      <= k + 1;
      h_prev <= h_cur;
      h_cur  <= int'(cnt);
    end
  end

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] exp_an(input int d);
    if (k == 0) return 2'b11;
    return (((k - 1) / div_of(d)) % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    if (k == 0)          return 7'h7F;
    if (h_prev > MAX_VAL) return 7'h3F;
    if (exp_an(d) == 2'b10) return GLYPH[h_prev % 10];
    if (h_prev / 10 == 0) return 7'h7F;
    return GLYPH[h_prev / 10];
  endfunction

  function automatic logic exp_wrap();
    return (k > 0) && (h_prev == MAX_VAL) && (h_cur == 0);
  endfunction

  task automatic cycle(input logic [4:0] v);
    @(negedge clk);
    cnt = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    cnt  = 5'd5;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle(5'd5); else #1;
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== 7'h7F || an_o[d] !== 2'b11 || wrap_o[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d: seg=%h an=%b wrap=%b expected seg=7f an=11 wrap=0",
                   d, seg_o[d], an_o[d], wrap_o[d]);
        end
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(5'd5);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL reset_release dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
  endtask

  task automatic test_digits();
    for (int i = 0; i < 20; i++) begin
      cycle((i < 10) ? 5'd13 : 5'd7);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL digits dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
  endtask

  task automatic test_sweep();
    int pulses = 0;
    for (int i = 0; i < 3 * (MAX_VAL + 1) + 2; i++) begin
      cycle(5'(i % (MAX_VAL + 1)));
      if (wrap_o[0] === 1'b1) pulses++;
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL sweep dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
    // Laps start at 0, so only the three 17->0 steps (not the first 0) produce a pulse.
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL sweep_pulse_count: got %0d pulses, expected 3", pulses);
    end
  endtask

  task automatic test_non_wrap();
    logic [4:0] seq [10] = '{5'd17, 5'd5, 5'd9, 5'd0, 5'd0, 5'd0, 5'd20, 5'd0, 5'd31, 5'd0};
    for (int i = 0; i < 12; i++) begin
      cycle((i < 10) ? seq[i] : 5'd3);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL non_wrap dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=0",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 16; i++) begin
      cycle((i < 8) ? 5'd20 : 5'd31);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL out_of_range dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] v;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 5'd0;
        1:       v = 5'(MAX_VAL);
        default: v = 5'($urandom_range(0, 31));
      endcase
      cycle(v);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL random dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
  endtask

  task automatic test_mid_scan_reset();
    int budget = 0;
    cycle(5'd16);
    while (an_o[2] !== 2'b01 && budget < 20) begin
      cycle(5'd16);
      budget++;
    end
    n_checks++;
    if (an_o[2] !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_wait: an=%b never reached 01 within 20 cycles", an_o[2]);
    end
    #2;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (seg_o[d] !== 7'h7F || an_o[d] !== 2'b11 || wrap_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_async dut%0d: seg=%h an=%b wrap=%b expected seg=7f an=11 wrap=0",
                 d, seg_o[d], an_o[d], wrap_o[d]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(5'd16);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (seg_o[d] !== exp_seg(d) || an_o[d] !== exp_an(d) || wrap_o[d] !== exp_wrap()) begin
          n_fail++;
          $display("FAIL mid_reset_restart dut%0d edge%0d: seg=%h an=%b wrap=%b expected seg=%h an=%b wrap=%b",
                   d, k, seg_o[d], an_o[d], wrap_o[d], exp_seg(d), exp_an(d), exp_wrap());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_sweep();
    test_non_wrap();
    test_out_of_range();
    test_random();
    test_mid_scan_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
